// File: rtl/i2s_dsp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2s_dsp_pkg
// Description : Shared widths, FSM state encoding and a small helper for the
//               DSP-mode I2S frame controller.
//               Contents:
//                 c_bit_w   - width of bit index / bits-per-word config
//                 c_slot_w  - width of slot index / words-per-frame config
//                 c_setup_w - width of setup-time config and counter
//                 dsp_state_e - IDLE / SETUP / RUN / DRAIN
// Revision    : 1.0 - initial release
// ============================================================================
package i2s_dsp_pkg;

  localparam int c_bit_w   = 5;
  localparam int c_slot_w  = 4;
  localparam int c_setup_w = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } dsp_state_e;

  // True for every state in which the serial interface is owned by a run.
  function automatic logic is_active(input dsp_state_e s);
    return (s != ST_IDLE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_dsp_slot_cnt.sv
`default_nettype none
// ============================================================================
// Module      : i2s_dsp_slot_cnt
// Description : Bit / slot position counter for one DSP frame. The bit index
//               counts down from num_bits to 0 (MSB first); at 0 it reloads
//               and the slot index advances, wrapping after num_words.
//               Ports:
//                 sck_i, rstn_i    - bit clock, async active-low reset
//                 clear_i          - force position to 0 and flags low
//                 load_i           - start a frame: bit=num_bits, slot=0
//                 adv_i            - step one bit cycle
//                 num_bits_i       - bits per word minus 1
//                 num_words_i      - words per frame minus 1
//                 bit_o, slot_o    - registered position
//                 word_done_o      - registered, last bit of a word
//                 frame_start_o    - registered, first bit of a frame
//                 frame_end_o      - last bit of the last word (decoded)
//               Priority: clear_i > load_i > adv_i; with none asserted the
//               position holds and the flags drop.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_dsp_slot_cnt
  import i2s_dsp_pkg::*;
(
  input  logic                sck_i,
  input  logic                rstn_i,
  input  logic                clear_i,
  input  logic                load_i,
  input  logic                adv_i,
  input  logic [c_bit_w-1:0]  num_bits_i,
  input  logic [c_slot_w-1:0] num_words_i,
  output logic [c_bit_w-1:0]  bit_o,
  output logic [c_slot_w-1:0] slot_o,
  output logic                word_done_o,
  output logic                frame_start_o,
  output logic                frame_end_o
);

  logic [c_bit_w-1:0]  r_bit;
  logic [c_slot_w-1:0] r_slot;
  logic                r_word_done;
  logic                r_frame_start;

  logic [c_bit_w-1:0]  w_bit_nxt;
  logic [c_slot_w-1:0] w_slot_nxt;
  logic                w_active_nxt;

  always_comb begin
    w_bit_nxt    = r_bit;
    w_slot_nxt   = r_slot;
    w_active_nxt = 1'b0;
    if (clear_i) begin
      w_bit_nxt  = '0;
      w_slot_nxt = '0;
    end else if (load_i) begin
      w_bit_nxt    = num_bits_i;
      w_slot_nxt   = '0;
      w_active_nxt = 1'b1;
    end else if (adv_i) begin
      w_active_nxt = 1'b1;
      if (r_bit == '0) begin
        w_bit_nxt  = num_bits_i;
        w_slot_nxt = (r_slot == num_words_i) ? '0 : (r_slot + c_slot_w'(1));
      end else begin
        w_bit_nxt = r_bit - c_bit_w'(1);
      end
    end
  end

  // Flags are computed from the next position so they line up with the
  // registered bit/slot values in the same cycle.
  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_bit         <= '0;
      r_slot        <= '0;
      r_word_done   <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_bit         <= w_bit_nxt;
      r_slot        <= w_slot_nxt;
      r_word_done   <= w_active_nxt && (w_bit_nxt == '0);
      r_frame_start <= w_active_nxt && (w_slot_nxt == '0) && (w_bit_nxt == num_bits_i);
    end
  end

  assign bit_o         = r_bit;
  assign slot_o        = r_slot;
  assign word_done_o   = r_word_done;
  assign frame_start_o = r_frame_start;
  assign frame_end_o   = r_word_done && (r_slot == num_words_i);

endmodule
`default_nettype wire

// File: rtl/i2s_dsp_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : i2s_dsp_frame_ctrl
// Description : Frame sequencer for a DSP-mode I2S transmitter/receiver.
//               Runs an optional setup period, then counts bits/slots of
//               back-to-back frames until a frame limit is reached or the
//               run request drops (the current frame is then finished).
//               Ports:
//                 sck_i            - serial bit clock (posedge logic)
//                 rstn_i           - async active-low reset
//                 cfg_en_i         - run request level
//                 cfg_num_bits_i   - bits per word minus 1
//                 cfg_num_words_i  - slots per frame minus 1
//                 cfg_setup_time_i - setup cycles before the first frame
//                 cfg_num_frames_i - frames to run, 0 = continuous
//                 ws_en_o          - enable to the WS generator
//                 frame_start_o    - first bit cycle of each frame
//                 word_done_o      - last bit cycle of each word
//                 slot_o, bit_o    - current slot / bit position
//                 busy_o           - not idle
//                 done_o           - one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_dsp_frame_ctrl
  import i2s_dsp_pkg::*;
#(
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   sck_i,
  input  logic                   rstn_i,
  input  logic                   cfg_en_i,
  input  logic [c_bit_w-1:0]     cfg_num_bits_i,
  input  logic [c_slot_w-1:0]    cfg_num_words_i,
  input  logic [c_setup_w-1:0]   cfg_setup_time_i,
  input  logic [FRAME_CNT_W-1:0] cfg_num_frames_i,
  output logic                   ws_en_o,
  output logic                   frame_start_o,
  output logic                   word_done_o,
  output logic [c_slot_w-1:0]    slot_o,
  output logic [c_bit_w-1:0]     bit_o,
  output logic                   busy_o,
  output logic                   done_o
);

  dsp_state_e r_state;
  dsp_state_e w_state_nxt;

  // Shadow copies of the configuration, captured on leaving IDLE. The setup
  // time needs no separate shadow: it is loaded straight into the setup
  // down-counter at that moment.
  logic [c_bit_w-1:0]     r_num_bits;
  logic [c_slot_w-1:0]    r_num_words;
  logic [FRAME_CNT_W-1:0] r_num_frames;

  logic [c_setup_w-1:0]   r_setup_cnt;
  logic [c_setup_w-1:0]   w_setup_nxt;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;
  logic [FRAME_CNT_W-1:0] w_frame_nxt;

  logic r_ws_en;
  logic r_busy;
  logic r_done;
  logic w_done_nxt;
  logic w_capture;

  logic w_cnt_clear;
  logic w_cnt_load;
  logic w_cnt_adv;
  logic w_frame_end;
  logic w_last_frame;

  logic [c_bit_w-1:0]  w_bits_sel;
  logic [c_slot_w-1:0] w_words_sel;

  // The counter load on IDLE exit happens on the same edge that captures
  // the shadow registers, so it must see the live config inputs.
  assign w_bits_sel  = (r_state == ST_IDLE) ? cfg_num_bits_i  : r_num_bits;
  assign w_words_sel = (r_state == ST_IDLE) ? cfg_num_words_i : r_num_words;

  i2s_dsp_slot_cnt u_slot_cnt (
    .sck_i         (sck_i),
    .rstn_i        (rstn_i),
    .clear_i       (w_cnt_clear),
    .load_i        (w_cnt_load),
    .adv_i         (w_cnt_adv),
    .num_bits_i    (w_bits_sel),
    .num_words_i   (w_words_sel),
    .bit_o         (bit_o),
    .slot_o        (slot_o),
    .word_done_o   (word_done_o),
    .frame_start_o (frame_start_o),
    .frame_end_o   (w_frame_end)
  );

  // The frame counter only advances for a finite run, so it stays 0 in
  // continuous mode and is never compared there.
  assign w_last_frame = (r_num_frames != '0) &&
                        ((r_frame_cnt + FRAME_CNT_W'(1)) == r_num_frames);

  always_comb begin
    w_state_nxt = r_state;
    w_setup_nxt = r_setup_cnt;
    w_frame_nxt = r_frame_cnt;
    w_done_nxt  = 1'b0;
    w_capture   = 1'b0;
    w_cnt_clear = 1'b0;
    w_cnt_load  = 1'b0;
    w_cnt_adv   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_cnt_clear = 1'b1;
        if (cfg_en_i) begin
          w_capture   = 1'b1;
          w_cnt_clear = 1'b0;
          w_frame_nxt = '0;
          if (cfg_setup_time_i != '0) begin
            w_state_nxt = ST_SETUP;
            w_setup_nxt = cfg_setup_time_i - c_setup_w'(1);
          end else begin
            w_state_nxt = ST_RUN;
            w_cnt_load  = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        if (!cfg_en_i) begin
          // Abort before any frame has started: no completion pulse.
          w_state_nxt = ST_IDLE;
          w_cnt_clear = 1'b1;
          w_setup_nxt = '0;
        end else if (r_setup_cnt == '0) begin
          w_state_nxt = ST_RUN;
          w_cnt_load  = 1'b1;
        end else begin
          w_setup_nxt = r_setup_cnt - c_setup_w'(1);
        end
      end
      ST_RUN: begin
        if (w_frame_end) begin
          // Limit reached and/or run request dropped on the final bit:
          // either way the frame is complete, so a single done pulse.
          if (w_last_frame || !cfg_en_i) begin
            w_state_nxt = ST_IDLE;
            w_cnt_clear = 1'b1;
            w_done_nxt  = 1'b1;
            w_frame_nxt = '0;
          end else begin
            w_cnt_adv = 1'b1;
            if (r_num_frames != '0) begin
              w_frame_nxt = r_frame_cnt + FRAME_CNT_W'(1);
            end
          end
        end else begin
          w_cnt_adv = 1'b1;
          if (!cfg_en_i) begin
            w_state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Committed: cfg_en_i is ignored until the frame has finished.
        if (w_frame_end) begin
          w_state_nxt = ST_IDLE;
          w_cnt_clear = 1'b1;
          w_done_nxt  = 1'b1;
          w_frame_nxt = '0;
        end else begin
          w_cnt_adv = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state      <= ST_IDLE;
      r_num_bits   <= '0;
      r_num_words  <= '0;
      r_num_frames <= '0;
      r_setup_cnt  <= '0;
      r_frame_cnt  <= '0;
      r_ws_en      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_setup_cnt <= w_setup_nxt;
      r_frame_cnt <= w_frame_nxt;
      r_ws_en     <= is_active(w_state_nxt);
      r_busy      <= is_active(w_state_nxt);
      r_done      <= w_done_nxt;
      if (w_capture) begin
        r_num_bits   <= cfg_num_bits_i;
        r_num_words  <= cfg_num_words_i;
        r_num_frames <= cfg_num_frames_i;
      end
    end
  end

  assign ws_en_o = r_ws_en;
  assign busy_o  = r_busy;
  assign done_o  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_i2s_dsp_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_dsp_frame_ctrl
// Description : Self-checking bench for i2s_dsp_frame_ctrl. A cycle model
//               derives each expected output word from the cycle index
//               since start (setup offset, frame/slot/bit by division) and
//               queues it when stimulus is driven; the DUT outputs are
//               popped and compared one cycle later on the falling edge.
//               Per-scenario event timing is also checked against fixed
//               cycle numbers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_dsp_frame_ctrl;
  localparam int FRAME_CNT_W = 16;

  logic                   sck_i = 1'b0;
  logic                   rstn_i;
  logic                   cfg_en_i;
  logic [4:0]             cfg_num_bits_i;
  logic [3:0]             cfg_num_words_i;
  logic [15:0]            cfg_setup_time_i;
  logic [FRAME_CNT_W-1:0] cfg_num_frames_i;
  logic                   ws_en_o, frame_start_o, word_done_o, busy_o, done_o;
  logic [3:0]             slot_o;
  logic [4:0]             bit_o;

  i2s_dsp_frame_ctrl #(.FRAME_CNT_W(FRAME_CNT_W)) dut (
    .sck_i            (sck_i),
    .rstn_i           (rstn_i),
    .cfg_en_i         (cfg_en_i),
    .cfg_num_bits_i   (cfg_num_bits_i),
    .cfg_num_words_i  (cfg_num_words_i),
    .cfg_setup_time_i (cfg_setup_time_i),
    .cfg_num_frames_i (cfg_num_frames_i),
    .ws_en_o          (ws_en_o),
    .frame_start_o    (frame_start_o),
    .word_done_o      (word_done_o),
    .slot_o           (slot_o),
    .bit_o            (bit_o),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  always #5 sck_i = ~sck_i;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  // Output word: {ws, fs, wd, busy, done, slot[3:0], bit[4:0]}
  logic [13:0] exp_q[$];
  int m_act = 0, m_k = 0, m_lastf = 0;
  int m_nb = 0, m_nw = 0, m_su = 0, m_nf = 0;

  function automatic logic [13:0] obs_word();
    return {ws_en_o, frame_start_o, word_done_o, busy_o, done_o, slot_o, bit_o};
  endfunction

  task automatic model_step(input logic en);
    int p, flen, f, r, bitv, slotv;
    logic done_n, fs, wd;
    logic [13:0] e;
    done_n = 1'b0;
    if (m_act == 0) begin
      if (en) begin
        m_act = 1; m_k = 0;
        m_nb = int'(cfg_num_bits_i); m_nw = int'(cfg_num_words_i);
        m_su = int'(cfg_setup_time_i); m_nf = int'(cfg_num_frames_i);
        m_lastf = (m_nf == 0) ? 32'h7fffffff : m_nf - 1;
      end
    end else begin
      p = m_k - m_su;
      flen = (m_nb + 1) * (m_nw + 1);
      if (p < 0) begin
        if (!en) m_act = 0;
        else     m_k++;
      end else begin
        f = p / flen;
        r = p % flen;
        if (!en && f < m_lastf) m_lastf = f;
        if (r == flen - 1 && f == m_lastf) begin
          m_act = 0; done_n = 1'b1;
        end else begin
          m_k++;
        end
      end
    end
    if (m_act == 0) begin
      e = {1'b0, 1'b0, 1'b0, 1'b0, done_n, 4'd0, 5'd0};
    end else begin
      p = m_k - m_su;
      if (p < 0) begin
        e = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 5'd0};
      end else begin
        flen  = (m_nb + 1) * (m_nw + 1);
        r     = p % flen;
        slotv = r / (m_nb + 1);
        bitv  = m_nb - (r % (m_nb + 1));
        fs    = (r == 0);
        wd    = (bitv == 0);
        e = {1'b1, fs, wd, 1'b1, 1'b0, 4'(slotv), 5'(bitv)};
      end
    end
    exp_q.push_back(e);
  endtask

  // ---------------- per-scenario event statistics ----------------
  int c;
  int first_ws, last_ws, first_fs, last_fs, first_done, last_done;
  int n_fs, n_wd, n_done, fs_bit;

  task automatic clear_stats();
    c = 0; first_ws = -1; last_ws = -1; first_fs = -1; last_fs = -1;
    first_done = -1; last_done = -1; n_fs = 0; n_wd = 0; n_done = 0; fs_bit = -1;
  endtask

  task automatic tick();
    logic [13:0] o;
    model_step(cfg_en_i);
    @(posedge sck_i);
    @(negedge sck_i);
    c++;
    o = obs_word();
    if (exp_q.size() == 0) check_val("sb_empty", 32'd1, 32'd0);
    else check_val($sformatf("cyc%0d_out", c), 32'(o), 32'(exp_q.pop_front()));
    if (ws_en_o) begin
      if (first_ws < 0) first_ws = c;
      last_ws = c;
    end
    if (frame_start_o) begin
      if (first_fs < 0) begin first_fs = c; fs_bit = int'(bit_o); end
      last_fs = c; n_fs++;
    end
    if (word_done_o) n_wd++;
    if (done_o) begin
      if (first_done < 0) first_done = c;
      last_done = c; n_done++;
    end
  endtask

  // en(c) = (c < drop) || (rise <= c < rise_end)
  task automatic run_scn(input int nb, input int nw, input int su, input int nf,
                         input int drop, input int rise, input int rise_end, input int ncyc);
    cfg_num_bits_i   = 5'(nb);
    cfg_num_words_i  = 4'(nw);
    cfg_setup_time_i = 16'(su);
    cfg_num_frames_i = FRAME_CNT_W'(nf);
    clear_stats();
    for (int i = 0; i < ncyc; i++) begin
      cfg_en_i = (c < drop) || (c >= rise && c < rise_end);
      tick();
    end
    cfg_en_i = 1'b0;
  endtask

  initial begin
    rstn_i = 1'b0; cfg_en_i = 1'b0;
    cfg_num_bits_i = '0; cfg_num_words_i = '0; cfg_setup_time_i = '0; cfg_num_frames_i = '0;
    repeat (2) @(negedge sck_i);
    check_val("reset_outputs", 32'(obs_word()), 32'd0);
    rstn_i = 1'b1;

    // No run request after reset: must stay idle.
    run_scn(15, 1, 0, 0, 0, 0, 0, 3);
    check_val("idle_no_ws", 32'(first_ws), 32'hffffffff);

    // Setup then two frames of 2x16 bits.
    run_scn(15, 1, 3, 2, 68, 0, 0, 72);
    check_val("A_ws_rise", 32'(first_ws), 32'd1);
    check_val("A_fs_first", 32'(first_fs), 32'd4);
    check_val("A_fs_last", 32'(last_fs), 32'd36);
    check_val("A_done_at", 32'(first_done), 32'd68);
    check_val("A_done_cnt", 32'(n_done), 32'd1);

    // No setup: frame starts with ws_en.
    run_scn(15, 1, 0, 2, 65, 0, 0, 70);
    check_val("B_fs_first", 32'(first_fs), 32'd1);
    check_val("B_ws_rise", 32'(first_ws), 32'd1);
    check_val("B_wd_cnt", 32'(n_wd), 32'd4);
    check_val("B_done_at", 32'(first_done), 32'd65);

    // Continuous, request dropped at slot 1 bit 7.
    run_scn(15, 1, 0, 0, 25, 0, 0, 40);
    check_val("C_done_at", 32'(first_done), 32'd33);
    check_val("C_ws_last", 32'(last_ws), 32'd32);
    check_val("C_fs_cnt", 32'(n_fs), 32'd1);

    // Request dropped during setup: silent abort.
    run_scn(15, 1, 10, 0, 5, 0, 0, 15);
    check_val("D_ws_last", 32'(last_ws), 32'd5);
    check_val("D_fs_cnt", 32'(n_fs), 32'd0);
    check_val("D_done_cnt", 32'(n_done), 32'd0);

    // Single-bit single-slot frames.
    run_scn(0, 0, 0, 3, 4, 0, 0, 8);
    check_val("F_fs_cnt", 32'(n_fs), 32'd3);
    check_val("F_wd_cnt", 32'(n_wd), 32'd3);
    check_val("F_done_at", 32'(first_done), 32'd4);

    // Frame limit and request drop on the same final bit.
    run_scn(1, 0, 0, 2, 4, 0, 0, 10);
    check_val("H_done_cnt", 32'(n_done), 32'd1);
    check_val("H_done_at", 32'(first_done), 32'd5);

    // Drain is committed; re-raised request restarts after an idle cycle.
    run_scn(3, 1, 0, 0, 3, 5, 11, 25);
    check_val("G_done_at", 32'(first_done), 32'd9);
    check_val("G_done_last", 32'(last_done), 32'd18);
    check_val("G_done_cnt", 32'(n_done), 32'd2);

    // Mid-run config change is ignored; async reset clears everything.
    cfg_num_bits_i = 5'd3; cfg_num_words_i = 4'd1; cfg_setup_time_i = '0; cfg_num_frames_i = '0;
    clear_stats();
    for (int i = 0; i < 8; i++) begin
      cfg_en_i = 1'b1;
      if (c == 4) cfg_num_bits_i = 5'd7;
      tick();
    end
    #2 rstn_i = 1'b0;
    #1 check_val("rst_async_outputs", 32'(obs_word()), 32'd0);
    exp_q.delete();
    m_act = 0;
    @(posedge sck_i);
    @(negedge sck_i);
    check_val("rst_hold_outputs", 32'(obs_word()), 32'd0);
    rstn_i = 1'b1;
    run_scn(7, 0, 0, 1, 9, 0, 0, 12);
    check_val("E_fs_bit", 32'(fs_bit), 32'd7);
    check_val("E_done_at", 32'(first_done), 32'd9);

    check_val("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2s_dsp_frame_ctrl.md
I2S_DSP_FRAME_CTRL -- requirements
Module: i2s_dsp_frame_ctrl

Interface
REQ-001 The block SHALL have parameter FRAME_CNT_W, default 16, width of the frame-count config and counter.
REQ-002 The block SHALL have port sck_i  in  1  serial bit clock; all logic on posedge.
REQ-003 The block SHALL have port rstn_i  in  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port cfg_en_i  in  1  run request level, already synchronous to sck_i.
REQ-005 The block SHALL have port cfg_num_bits_i  in  5  bits per word minus 1.
REQ-006 The block SHALL have port cfg_num_words_i  in  4  words (slots) per frame minus 1.
REQ-007 The block SHALL have port cfg_setup_time_i  in  16  setup cycles before first frame.
REQ-008 The block SHALL have port cfg_num_frames_i  in  FRAME_CNT_W  frames to run; 0 = continuous.
REQ-009 The block SHALL have port ws_en_o  out  1  enable to the DSP WS generator.
REQ-010 The block SHALL have port frame_start_o  out  1  pulse on first bit cycle of each frame.
REQ-011 The block SHALL have port word_done_o  out  1  pulse on last bit cycle of each word.
REQ-012 The block SHALL have port slot_o  out  4  current word index, 0-based.
REQ-013 The block SHALL have port bit_o  out  5  current bit index, counting down from cfg_num_bits to 0 (MSB first).
REQ-014 The block SHALL have port busy_o  out  1  high in any state except IDLE.
REQ-015 The block SHALL have port done_o  out  1  one-cycle pulse on completion or graceful stop.

Function
REQ-016 The FSM SHALL have states IDLE, SETUP, RUN, DRAIN, with all outputs registered.
REQ-017 On a sampled cfg_en_i=1 in IDLE, the block SHALL shadow all cfg_* inputs; changes to cfg_* SHALL be ignored until the next return to IDLE.
REQ-018 On that IDLE exit, the block SHALL go to SETUP if setup_time!=0, else to RUN; ws_en_o SHALL rise in the first non-IDLE cycle.
REQ-019 SETUP SHALL last exactly setup_time cycles with ws_en_o=1, frame_start_o=0, word_done_o=0, and then enter RUN.
REQ-020 RUN/DRAIN bit_o SHALL decrement each cycle; at bit_o=0 the block SHALL pulse word_done_o, reload bit_o to num_bits, and advance slot_o, wrapping from num_words to 0.
REQ-021 frame_start_o SHALL be 1 in cycles where slot_o=0 and bit_o=num_bits.
- Frame length = (num_bits+1)*(num_words+1) cycles.
REQ-022 Arithmetic: frame counter is FRAME_CNT_W bits, incremented at frame end; it SHALL not be compared and SHALL hold 0 when num_frames=0.
REQ-023 After frame end where count == num_frames (num_frames!=0), next cycle SHALL be IDLE, with done_o=1 and ws_en_o=0 for that cycle.
REQ-024 cfg_en_i=0 in RUN SHALL move to DRAIN; the current frame SHALL complete, then IDLE with done_o=1.
REQ-025 DRAIN SHALL be committed; cfg_en_i re-rising in DRAIN SHALL not cancel it, and restart SHALL require one IDLE cycle.
REQ-026 cfg_en_i=0 in SETUP SHALL abort to IDLE next cycle with no done_o pulse.
REQ-027 If the frame-count limit and cfg_en_i=0 coincide, the block SHALL produce a single done_o pulse.
REQ-028 Boundary: num_bits=0 gives frame_start_o and word_done_o every cycle when num_words=0.
- Boundary: num_words=0 gives slot_o constant 0.
REQ-029 In IDLE, ws_en_o, frame_start_o, word_done_o and busy_o SHALL be 0, slot_o=0 and bit_o=0.

Reset
REQ-030 Asserting rstn_i SHALL immediately force IDLE, all outputs 0, and all counters and shadow config 0, including mid-frame.
REQ-031 After reset release, the block SHALL need a cfg_en_i sample in IDLE to start.

Structure
REQ-032 Package i2s_dsp_pkg SHALL hold the FSM state enum and width constants (bit, slot and setup widths).
REQ-033 Bit/slot counting SHALL be one sub-module, i2s_dsp_slot_cnt (load, decrement, wrap, word_done and frame_end flags); the FSM and frame counter SHALL stay in the top.

Verification
REQ-034 bits=15, words=1, setup=3, frames=2, cfg_en_i high -> ws_en_o rises cycle 1; frame_start_o at cycles 4 and 36; done_o at cycle 68.
REQ-035 Same config with setup=0 -> frame_start_o in the same cycle ws_en_o rises; word_done_o every 16 cycles; slot_o toggles 0/1.
REQ-036 frames=0, cfg_en_i dropped mid-frame at slot 1 bit 7 -> frame finishes (8 more cycles), then done_o=1, ws_en_o=0.
REQ-037 cfg_en_i dropped during SETUP (setup=10, after 4 cycles) -> IDLE next cycle, no done_o, no frame_start_o.
REQ-038 rstn_i asserted mid-RUN, then cfg_num_bits changed during RUN -> all outputs 0 immediately; new bits used only after restart.
REQ-039 bits=0, words=0, frames=3 -> frame_start_o and word_done_o high 3 consecutive cycles, then done_o.
